inst_router: RTL and testbench
==============================

INST_ROUTER -- requirements
Module: inst_router

Interface
REQ-001 SHALL have parameter INST_ID_BITS, default 6, instruction tag width.
REQ-002 SHALL have parameter PRN_BITS, default 6, physical register number width.
REQ-003 SHALL have parameter MAX_OPERANDS, default 3, operand slots per instruction.
REQ-004 SHALL have parameter FU_COUNT, default 4, number of issue queues served.
REQ-005 SHALL have parameter DEPTH, default 4, staging FIFO entries (power of two).
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports in_valid input 1 and in_ready output 1, the rename-side handshake.
REQ-009 SHALL have payload inputs: in_fu_sel $clog2(FU_COUNT), in_inst_id INST_ID_BITS, in_raw_instr 32, in_instr_pc 64, in_prn_input_valid[MAX_OPERANDS] 1, in_prn_input[MAX_OPERANDS] PRN_BITS, in_prn_output_valid[MAX_OPERANDS] 1, in_prn_output[MAX_OPERANDS] PRN_BITS.
REQ-010 SHALL have ports inst_valid[FU_COUNT] output 1 and queue_ready[FU_COUNT] input 1, the per-queue dispatch handshake.
REQ-011 SHALL drive a shared output bus: inst_id, raw_instr, instr_pc, prn_input_valid[], prn_input[], prn_input_ready[MAX_OPERANDS], prn_output_valid[], prn_output[], widths as the in_* counterparts.
REQ-012 SHALL have inputs set_prn_ready[FU_COUNT][MAX_OPERANDS] 1 and set_prn[FU_COUNT][MAX_OPERANDS] PRN_BITS, the FU writeback broadcasts.
REQ-013 SHALL have input flush, 1, synchronous pipeline flush.
REQ-014 SHALL have output stall_count, 16, saturating count of head-blocked cycles.

Function
REQ-015 SHALL accept a payload into the FIFO tail on in_valid && in_ready; in_ready SHALL be 1 iff occupancy < DEPTH (no same-cycle pass-through when full).
REQ-016 SHALL present the FIFO head on the shared bus whenever occupancy > 0; minimum latency from accept to inst_valid is 1 cycle.
REQ-017 SHALL assert inst_valid[head.fu_sel] iff head valid and queue_ready[head.fu_sel] is 1, in the same cycle; all other inst_valid bits 0.
REQ-018 SHALL pop the head in every cycle inst_valid is asserted; dispatch is strictly in order and head-of-line blocking.
REQ-019 SHALL support simultaneous push and pop, occupancy unchanged; pointers wrap modulo DEPTH.
REQ-020 SHALL keep a ready scoreboard of 2^PRN_BITS bits, all 1 after reset.
REQ-021 SHALL set scoreboard[set_prn[f][k]] for every asserted set_prn_ready[f][k] at the clock edge.
REQ-022 SHALL clear scoreboard[prn_output[k]] for each valid prn_output slot of a dispatched instruction; clear SHALL win over a same-cycle set to the same PRN.
REQ-023 SHALL drive prn_input_ready[k] = scoreboard[prn_input[k]] OR any same-cycle set_prn_ready matching prn_input[k] (bypass); 0 when prn_input_valid[k] is 0.
REQ-024 SHALL increment stall_count each cycle head is valid and not dispatched, saturating at 16'hFFFF.
REQ-025 SHALL on flush empty the FIFO and suppress inst_valid that cycle; scoreboard and stall_count SHALL be unchanged; in_valid during flush SHALL be dropped.

Reset
REQ-026 SHALL on rst low asynchronously clear pointers and occupancy, set all scoreboard bits to 1, and clear stall_count.
REQ-027 SHALL during reset drive in_ready 0, all inst_valid 0, and the shared bus 0.
REQ-028 SHALL drive in_ready 1 in the first cycle after reset release; an in-flight payload at reset assertion is discarded.

Structure
REQ-029 SHALL place the dispatch payload struct and the FU select width in the shared core package, reused by the issue queue.
REQ-030 SHALL implement the scoreboard as sub-module prn_scoreboard; FIFO and dispatch logic stay in inst_router.

Verification
REQ-031 SHALL test: push inst_id 5, fu_sel 2, queue_ready all 1 -> inst_valid[2]=1 one cycle later, inst_id=5, stall_count 0.
REQ-032 SHALL test: 4 pushes with queue_ready[1]=0, fu_sel 1 -> in_ready=0 after 4th, stall_count increments each cycle, releasing queue_ready[1] drains 4 in order over 4 cycles.
REQ-033 SHALL test: dispatch prn_output 9, later source prn_input 9 -> prn_input_ready 0; set_prn 9 broadcast same cycle -> 1 (bypass), next cycle 1 from scoreboard.
REQ-034 SHALL test: dispatch dest 12 and set_prn 12 same cycle -> scoreboard[12]=0 afterward.
REQ-035 SHALL test: flush with 3 entries queued -> occupancy 0, no inst_valid, in_ready 1 next cycle.
REQ-036 SHALL test: rst low mid-drain -> all inst_valid 0 immediately, scoreboard all 1 after release.

Source files
------------

// File: rtl/inst_router_pkg.sv
// rtl/inst_router_pkg.sv - shared core types and widths for rename-to-issue dispatch
package inst_router_pkg;

  localparam int CORE_INST_ID_BITS = 6;
  localparam int CORE_PRN_BITS     = 6;
  localparam int CORE_MAX_OPERANDS = 3;
  localparam int CORE_FU_COUNT     = 4;

  // Select field width for a given number of issue queues (never zero wide)
  function automatic int sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int FU_SEL_BITS = sel_bits(CORE_FU_COUNT);

  // Dispatch payload as seen by the issue queues at the default core configuration
  typedef struct packed {
    logic [FU_SEL_BITS-1:0]                             fu_sel;
    logic [CORE_INST_ID_BITS-1:0]                       inst_id;
    logic [31:0]                                        raw_instr;
    logic [63:0]                                        instr_pc;
    logic [CORE_MAX_OPERANDS-1:0]                       prn_input_valid;
    logic [CORE_MAX_OPERANDS-1:0][CORE_PRN_BITS-1:0]    prn_input;
    logic [CORE_MAX_OPERANDS-1:0]                       prn_output_valid;
    logic [CORE_MAX_OPERANDS-1:0][CORE_PRN_BITS-1:0]    prn_output;
  } dispatch_pkt_t;

endpackage

// File: rtl/prn_scoreboard.sv
// rtl/prn_scoreboard.sv - physical register ready bits with writeback bypass
module prn_scoreboard
  import inst_router_pkg::*;
#(
  parameter int PRN_BITS     = CORE_PRN_BITS,
  parameter int MAX_OPERANDS = CORE_MAX_OPERANDS,
  parameter int FU_COUNT     = CORE_FU_COUNT
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]               set_valid,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] set_prn,
  input  logic [MAX_OPERANDS-1:0]                             clr_valid,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]               clr_prn,
  input  logic [MAX_OPERANDS-1:0]                             qry_valid,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]               qry_prn,
  output logic [MAX_OPERANDS-1:0]                             qry_ready
);

  localparam int NREG = 1 << PRN_BITS;

  logic [NREG-1:0] ready_q;
  logic [NREG-1:0] ready_d;
  logic [NREG-1:0] set_mask;

  // Collapse every writeback broadcast into one per-register set mask
  always_comb begin
    set_mask = '0;
    for (int f = 0; f < FU_COUNT; f++) begin
      for (int k = 0; k < MAX_OPERANDS; k++) begin
        if (set_valid[f][k]) set_mask[set_prn[f][k]] = 1'b1;
      end
    end
  end

  // Apply sets first, then dispatch clears, so a new producer beats a stale writeback
  always_comb begin
    ready_d = ready_q | set_mask;
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      if (clr_valid[k]) ready_d[clr_prn[k]] = 1'b0;
    end
  end

  // Source readiness: stored bit or a writeback landing this very cycle
  always_comb begin
    qry_ready = '0;
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      qry_ready[k] = qry_valid[k] && (ready_q[qry_prn[k]] || set_mask[qry_prn[k]]);
    end
  end

  // Ready bits come out of reset all set: nothing is in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_q <= '1;
    else      ready_q <= ready_d;
  end

endmodule

// File: rtl/inst_router.sv
// rtl/inst_router.sv - staging FIFO that routes renamed instructions to issue queues
module inst_router
  import inst_router_pkg::*;
#(
  parameter int INST_ID_BITS = CORE_INST_ID_BITS,
  parameter int PRN_BITS     = CORE_PRN_BITS,
  parameter int MAX_OPERANDS = CORE_MAX_OPERANDS,
  parameter int FU_COUNT     = CORE_FU_COUNT,
  parameter int DEPTH        = 4
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic [sel_bits(FU_COUNT)-1:0]                       in_fu_sel,
  input  logic [INST_ID_BITS-1:0]                             in_inst_id,
  input  logic [31:0]                                         in_raw_instr,
  input  logic [63:0]                                         in_instr_pc,
  input  logic [MAX_OPERANDS-1:0]                             in_prn_input_valid,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]               in_prn_input,
  input  logic [MAX_OPERANDS-1:0]                             in_prn_output_valid,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]               in_prn_output,
  output logic [FU_COUNT-1:0]                                 inst_valid,
  input  logic [FU_COUNT-1:0]                                 queue_ready,
  output logic [INST_ID_BITS-1:0]                             inst_id,
  output logic [31:0]                                         raw_instr,
  output logic [63:0]                                         instr_pc,
  output logic [MAX_OPERANDS-1:0]                             prn_input_valid,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]               prn_input,
  output logic [MAX_OPERANDS-1:0]                             prn_input_ready,
  output logic [MAX_OPERANDS-1:0]                             prn_output_valid,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]               prn_output,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]               set_prn_ready,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] set_prn,
  input  logic                                                flush,
  output logic [15:0]                                         stall_count
);

  localparam int FSW   = sel_bits(FU_COUNT);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [FSW-1:0]                             fu_sel;
    logic [INST_ID_BITS-1:0]                    inst_id;
    logic [31:0]                                raw_instr;
    logic [63:0]                                instr_pc;
    logic [MAX_OPERANDS-1:0]                    prn_input_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]      prn_input;
    logic [MAX_OPERANDS-1:0]                    prn_output_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]      prn_output;
  } slot_t;

  slot_t             mem_q [DEPTH];
  slot_t             mem_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [15:0]       stall_q, stall_d;

  slot_t                   in_slot;
  slot_t                   head;
  logic                    head_valid;
  logic                    head_fu_ok;
  logic                    dispatch;
  logic                    push;
  logic [MAX_OPERANDS-1:0] clr_valid;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_slot = '{
    fu_sel:           in_fu_sel,
    inst_id:          in_inst_id,
    raw_instr:        in_raw_instr,
    instr_pc:         in_instr_pc,
    prn_input_valid:  in_prn_input_valid,
    prn_input:        in_prn_input,
    prn_output_valid: in_prn_output_valid,
    prn_output:       in_prn_output
  };

  // Holding rst in the gating keeps every output quiet while reset is asserted
  assign head_valid = rst && (count_q != '0);
  assign head       = head_valid ? mem_q[rd_ptr_q] : '0;
  assign head_fu_ok = 32'(head.fu_sel) < 32'(FU_COUNT);
  assign dispatch   = head_valid && !flush && head_fu_ok && queue_ready[head.fu_sel];
  assign in_ready   = rst && (count_q < CNT_W'(DEPTH));
  assign push       = in_valid && in_ready && !flush;
  assign clr_valid  = dispatch ? head.prn_output_valid : '0;

  assign inst_id          = head.inst_id;
  assign raw_instr        = head.raw_instr;
  assign instr_pc         = head.instr_pc;
  assign prn_input_valid  = head.prn_input_valid;
  assign prn_input        = head.prn_input;
  assign prn_output_valid = head.prn_output_valid;
  assign prn_output       = head.prn_output;
  assign stall_count      = stall_q;

  // One-hot valid toward the queue selected by the head entry
  always_comb begin
    inst_valid = '0;
    if (dispatch) inst_valid[head.fu_sel] = 1'b1;
  end

  // FIFO pointer/occupancy update and head-blocked stall accounting
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    stall_d  = stall_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_slot;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (dispatch) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, dispatch})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (head_valid && !dispatch && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    end
  end

  // Register FIFO state; reset discards any queued payloads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  prn_scoreboard #(
    .PRN_BITS     (PRN_BITS),
    .MAX_OPERANDS (MAX_OPERANDS),
    .FU_COUNT     (FU_COUNT)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_valid (set_prn_ready),
    .set_prn   (set_prn),
    .clr_valid (clr_valid),
    .clr_prn   (head.prn_output),
    .qry_valid (head.prn_input_valid),
    .qry_prn   (head.prn_input),
    .qry_ready (prn_input_ready)
  );

endmodule

// File: tb/tb_inst_router.sv
// tb/tb_inst_router.sv - self-checking bench for inst_router against a queue model
module tb_inst_router;

  localparam int DP = 4;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_fu_sel;
  logic [5:0]            in_inst_id;
  logic [31:0]           in_raw_instr;
  logic [63:0]           in_instr_pc;
  logic [2:0]            in_prn_input_valid;
  logic [2:0][5:0]       in_prn_input;
  logic [2:0]            in_prn_output_valid;
  logic [2:0][5:0]       in_prn_output;
  logic [3:0]            inst_valid;
  logic [3:0]            queue_ready;
  logic [5:0]            inst_id;
  logic [31:0]           raw_instr;
  logic [63:0]           instr_pc;
  logic [2:0]            prn_input_valid;
  logic [2:0][5:0]       prn_input;
  logic [2:0]            prn_input_ready;
  logic [2:0]            prn_output_valid;
  logic [2:0][5:0]       prn_output;
  logic [3:0][2:0]       set_prn_ready;
  logic [3:0][2:0][5:0]  set_prn;
  logic                  flush;
  logic [15:0]           stall_count;

  inst_router dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_fu_sel           (in_fu_sel),
    .in_inst_id          (in_inst_id),
    .in_raw_instr        (in_raw_instr),
    .in_instr_pc         (in_instr_pc),
    .in_prn_input_valid  (in_prn_input_valid),
    .in_prn_input        (in_prn_input),
    .in_prn_output_valid (in_prn_output_valid),
    .in_prn_output       (in_prn_output),
    .inst_valid          (inst_valid),
    .queue_ready         (queue_ready),
    .inst_id             (inst_id),
    .raw_instr           (raw_instr),
    .instr_pc            (instr_pc),
    .prn_input_valid     (prn_input_valid),
    .prn_input           (prn_input),
    .prn_input_ready     (prn_input_ready),
    .prn_output_valid    (prn_output_valid),
    .prn_output          (prn_output),
    .set_prn_ready       (set_prn_ready),
    .set_prn             (set_prn),
    .flush               (flush),
    .stall_count         (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]      fu;
    logic [5:0]      id;
    logic [31:0]     raw;
    logic [63:0]     pc;
    logic [2:0]      piv;
    logic [2:0][5:0] pi;
    logic [2:0]      pov;
    logic [2:0][5:0] po;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] msb;
  logic [15:0] mstall;
  int          n_checks;
  int          n_pass;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_fu_sel = '0; in_inst_id = '0; in_raw_instr = '0; in_instr_pc = '0;
    in_prn_input_valid = '0; in_prn_input = '0; in_prn_output_valid = '0; in_prn_output = '0;
    queue_ready = '0; set_prn_ready = '0; set_prn = '0; flush = 1'b0;
  endtask

  task automatic drive_in(input logic [1:0] fu, input logic [5:0] id, input logic [2:0] piv,
                          input logic [17:0] pi, input logic [2:0] pov, input logic [17:0] po);
    in_valid = 1'b1; in_fu_sel = fu; in_inst_id = id;
    in_raw_instr = $urandom; in_instr_pc = {$urandom, $urandom};
    in_prn_input_valid = piv; in_prn_input = pi;
    in_prn_output_valid = pov; in_prn_output = po;
  endtask

  task automatic rand_inputs();
    in_valid = ($urandom_range(0, 3) != 0);
    in_fu_sel = 2'($urandom);
    in_inst_id = 6'($urandom);
    in_raw_instr = $urandom;
    in_instr_pc = {$urandom, $urandom};
    in_prn_input_valid = 3'($urandom);
    in_prn_output_valid = 3'($urandom);
    for (int k = 0; k < 3; k++) begin
      in_prn_input[k] = 6'($urandom_range(0, 15));
      in_prn_output[k] = 6'($urandom_range(0, 15));
    end
    queue_ready = 4'($urandom);
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 3; k++) begin
        set_prn_ready[f][k] = ($urandom_range(0, 7) == 0);
        set_prn[f][k] = 6'($urandom_range(0, 15));
      end
    end
    flush = ($urandom_range(0, 31) == 0);
  endtask

  // Compare outputs to the model at the falling edge, then advance the model one clock
  task automatic cycle();
    ent_t        h;
    ent_t        cur;
    logic        hv, disp, inr;
    logic [3:0]  iv_e;
    logic [2:0]  pir_e;
    logic [63:0] setmask;
    @(negedge clk);
    setmask = '0;
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < 3; k++)
        if (set_prn_ready[f][k]) setmask[set_prn[f][k]] = 1'b1;
    hv   = rst && (mq.size() > 0);
    h    = hv ? mq[0] : '0;
    inr  = rst && (mq.size() < DP);
    disp = hv && !flush && queue_ready[h.fu];
    iv_e = disp ? (4'd1 << h.fu) : 4'd0;
    for (int k = 0; k < 3; k++) pir_e[k] = h.piv[k] && (msb[h.pi[k]] || setmask[h.pi[k]]);
    chk("in_ready", in_ready, inr);
    chk("inst_valid", inst_valid, iv_e);
    chk("inst_id", inst_id, h.id);
    chk("raw_instr", raw_instr, h.raw);
    chk("instr_pc", instr_pc, h.pc);
    chk("prn_input_valid", prn_input_valid, h.piv);
    chk("prn_input", prn_input, h.pi);
    chk("prn_input_ready", prn_input_ready, pir_e);
    chk("prn_output_valid", prn_output_valid, h.pov);
    chk("prn_output", prn_output, h.po);
    chk("stall_count", stall_count, mstall);
    cur = '{fu: in_fu_sel, id: in_inst_id, raw: in_raw_instr, pc: in_instr_pc,
            piv: in_prn_input_valid, pi: in_prn_input, pov: in_prn_output_valid, po: in_prn_output};
    if (rst) begin
      msb |= setmask;
      if (flush) begin
        mq.delete();
      end else begin
        if (disp) begin
          for (int k = 0; k < 3; k++) if (h.pov[k]) msb[h.po[k]] = 1'b0;
          void'(mq.pop_front());
        end
        if (in_valid && inr) mq.push_back(cur);
        if (hv && !disp && mstall != 16'hFFFF) mstall++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    msb = '1; mstall = '0;
    idle_inputs();
    rst = 1'b0;
    @(posedge clk); #1;
    repeat (3) cycle();
    rst = 1'b1;

    // single dispatch to queue 2
    queue_ready = 4'hF;
    drive_in(2'd2, 6'd5, 3'b000, 18'd0, 3'b000, 18'd0);
    cycle();
    in_valid = 1'b0;
    #1;
    chk("t1_inst_valid", inst_valid, 4'b0100);
    chk("t1_inst_id", inst_id, 6'd5);
    chk("t1_stall", stall_count, 16'd0);
    cycle();

    // fill behind a blocked queue, then drain in order
    queue_ready = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      drive_in(2'd1, 6'(10 + i), 3'b000, 18'd0, 3'b000, 18'd0);
      cycle();
    end
    in_valid = 1'b0;
    #1;
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_stall", stall_count, 16'd3);
    cycle();
    chk("blocked_stall", stall_count, 16'd4);
    queue_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_valid", inst_valid, 4'b0010);
      chk("drain_id", inst_id, 6'(10 + i));
      cycle();
    end
    chk("drain_empty", inst_valid, 4'b0000);
    chk("drain_stall_hold", stall_count, 16'd4);

    // destination 9 clears readiness; same-cycle writeback bypasses
    drive_in(2'd0, 6'd20, 3'b000, 18'd0, 3'b001, {12'd0, 6'd9});
    cycle();
    in_valid = 1'b0;
    cycle();
    queue_ready = 4'b0111;
    drive_in(2'd3, 6'd21, 3'b001, {12'd0, 6'd9}, 3'b000, 18'd0);
    cycle();
    in_valid = 1'b0;
    #1;
    chk("byp_not_ready", prn_input_ready[0], 1'b0);
    set_prn_ready[1][2] = 1'b1;
    set_prn[1][2] = 6'd9;
    #1;
    chk("byp_same_cycle", prn_input_ready[0], 1'b1);
    cycle();
    set_prn_ready = '0;
    #1;
    chk("byp_from_sb", prn_input_ready[0], 1'b1);
    queue_ready = 4'hF;
    cycle();

    // clear beats a same-cycle set on the dispatched destination
    drive_in(2'd0, 6'd22, 3'b000, 18'd0, 3'b001, {12'd0, 6'd12});
    cycle();
    in_valid = 1'b0;
    set_prn_ready[0][0] = 1'b1;
    set_prn[0][0] = 6'd12;
    cycle();
    set_prn_ready = '0;
    queue_ready = 4'b1011;
    drive_in(2'd2, 6'd23, 3'b001, {12'd0, 6'd12}, 3'b000, 18'd0);
    cycle();
    in_valid = 1'b0;
    #1;
    chk("clear_wins", prn_input_ready[0], 1'b0);
    queue_ready = 4'hF;
    cycle();

    // flush with three queued entries and a dropped push
    queue_ready = 4'h0;
    for (int i = 0; i < 3; i++) begin
      drive_in(2'(i), 6'(30 + i), 3'b000, 18'd0, 3'b000, 18'd0);
      cycle();
    end
    queue_ready = 4'hF;
    flush = 1'b1;
    drive_in(2'd0, 6'd40, 3'b000, 18'd0, 3'b000, 18'd0);
    #1;
    chk("flush_no_valid", inst_valid, 4'b0000);
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_empty_valid", inst_valid, 4'b0000);
    chk("flush_empty_bus", inst_id, 6'd0);
    cycle();

    // asynchronous reset in the middle of a drain
    queue_ready = 4'h0;
    for (int i = 0; i < 3; i++) begin
      drive_in(2'd1, 6'(50 + i), 3'b000, 18'd0, 3'b001, {12'd0, 6'(20 + i)});
      cycle();
    end
    in_valid = 1'b0;
    queue_ready = 4'hF;
    cycle();
    rst = 1'b0;
    mq.delete(); msb = '1; mstall = '0;
    #1;
    chk("rst_valid", inst_valid, 4'b0000);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_bus", inst_id, 6'd0);
    repeat (2) cycle();
    rst = 1'b1;
    queue_ready = 4'h0;
    drive_in(2'd0, 6'd60, 3'b111, {6'd12, 6'd21, 6'd9}, 3'b000, 18'd0);
    cycle();
    in_valid = 1'b0;
    #1;
    chk("rst_sb_ones", prn_input_ready, 3'b111);
    flush = 1'b1;
    cycle();
    flush = 1'b0;

    // randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      rand_inputs();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
